// File: rtl/mem_data_arb_pkg.sv
// Shared helpers for the arbitrated data memory: width functions and access-type encoding.
package mem_data_arb_pkg;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_e;

    // Width of an index over n items, never below 1 bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_data_arb_if.sv
// Core and external-channel signal bundle for mem_data_arb.
interface mem_data_arb_if #(
    parameter int NCHAN  = 2,
    parameter int AW     = 6,
    parameter int NBDATA = 16
);
    logic                         core_wr;
    logic [AW-1:0]                core_addr_w;
    logic [NBDATA-1:0]            core_din;
    logic                         core_rd;
    logic [AW-1:0]                core_addr_r;
    logic [NBDATA-1:0]            core_dout;
    logic [NCHAN-1:0]             ext_req;
    logic [NCHAN-1:0]             ext_we;
    logic [NCHAN-1:0][AW-1:0]     ext_addr;
    logic [NCHAN-1:0][NBDATA-1:0] ext_wdata;
    logic [NCHAN-1:0]             ext_gnt;
    logic [NCHAN-1:0]             ext_rvalid;
    logic [NBDATA-1:0]            ext_rdata;

    modport master (
        output core_wr, core_addr_w, core_din, core_rd, core_addr_r,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  core_dout, ext_gnt, ext_rvalid, ext_rdata
    );

    modport slave (
        input  core_wr, core_addr_w, core_din, core_rd, core_addr_r,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output core_dout, ext_gnt, ext_rvalid, ext_rdata
    );
endinterface

// File: rtl/mem_data_arb_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or above i_ptr, wrapping.
module mem_data_arb_rr_arbiter #(
    parameter int N  = 2,
    parameter int CW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_elig,
    input  logic [CW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [CW-1:0] o_nxt_ptr,
    output logic          o_any
);
    always_comb begin
        int idx;
        idx       = 0;
        o_gnt     = '0;
        o_nxt_ptr = i_ptr;
        o_any     = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(i_ptr) + off) % N;
            if (!o_any && i_req[idx] && i_elig[idx]) begin
                o_gnt[idx] = 1'b1;
                o_nxt_ptr  = CW'((idx + 1) % N);
                o_any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_data_arb.sv
// 1W/1R data memory shared by the core (always wins) and NCHAN round-robin external channels.
module mem_data_arb
    import mem_data_arb_pkg::*;
#(
    parameter int NADDRE = 64,
    parameter int NBDATA = 16,
    parameter int NCHAN  = 2,
    parameter int FWD    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_data_arb_if.slave bus
);
    localparam int AW = idx_w(NADDRE);
    localparam int CW = idx_w(NCHAN);

    logic [NBDATA-1:0] r_mem [NADDRE];
    logic [NBDATA-1:0] r_core_dout;
    logic [NBDATA-1:0] r_ext_rdata;
    logic [NCHAN-1:0]  r_rvalid;
    logic [CW-1:0]     r_ptr;

    logic [NCHAN-1:0]  w_elig;
    logic [NCHAN-1:0]  w_gnt_raw;
    logic [NCHAN-1:0]  w_gnt;
    logic [CW-1:0]     w_nxt_ptr;
    logic              w_any;
    logic [CW-1:0]     w_sel;
    logic              w_ext_wr;
    logic              w_ext_rd;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [NBDATA-1:0] w_wdata;
    logic [AW-1:0]     w_raddr;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [NBDATA-1:0] w_rdata;

    // A channel is eligible only if the port it needs is not taken by the core.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NCHAN; i++)
            w_elig[i] = (bus.ext_we[i] == ACC_WR) ? !bus.core_wr : !bus.core_rd;
    end

    mem_data_arb_rr_arbiter #(.N(NCHAN), .CW(CW)) u_arb (
        .i_req     (bus.ext_req),
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt_raw),
        .o_nxt_ptr (w_nxt_ptr),
        .o_any     (w_any)
    );

    assign w_gnt = rst_n ? w_gnt_raw : '0;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NCHAN; i++)
            if (w_gnt[i]) w_sel = CW'(i);
    end

    assign w_ext_wr = |(w_gnt & bus.ext_we);
    assign w_ext_rd = |(w_gnt & ~bus.ext_we);

    assign w_we    = bus.core_wr | w_ext_wr;
    assign w_waddr = bus.core_wr ? bus.core_addr_w : bus.ext_addr[w_sel];
    assign w_wdata = bus.core_wr ? bus.core_din    : bus.ext_wdata[w_sel];
    assign w_raddr = bus.core_rd ? bus.core_addr_r : bus.ext_addr[w_sel];

    // Addresses past the array (non-power-of-two depth) drop writes and read as zero.
    assign w_wr_ok = w_we && (32'(w_waddr) < 32'(NADDRE));
    assign w_rd_ok = 32'(w_raddr) < 32'(NADDRE);

    always_comb begin
        w_rdata = '0;
        if (w_rd_ok) begin
            if (FWD != 0 && w_wr_ok && w_waddr == w_raddr) w_rdata = w_wdata;
            else                                            w_rdata = r_mem[w_raddr];
        end
    end

    always_ff @(posedge clk)
        if (w_wr_ok) r_mem[w_waddr] <= w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_dout <= '0;
            r_ext_rdata <= '0;
            r_rvalid    <= '0;
            r_ptr       <= '0;
        end else begin
            if (bus.core_rd) r_core_dout <= w_rdata;
            if (w_ext_rd)    r_ext_rdata <= w_rdata;
            r_rvalid <= w_gnt & ~bus.ext_we;
            if (w_any)       r_ptr <= w_nxt_ptr;
        end
    end

    assign bus.core_dout  = r_core_dout;
    assign bus.ext_gnt    = w_gnt;
    assign bus.ext_rvalid = r_rvalid;
    assign bus.ext_rdata  = r_ext_rdata;
endmodule

// File: tb/tb_mem_data_arb.sv
// Directed checks of mem_data_arb: a 4-channel FWD=1 instance and a 2-channel FWD=0, 48-word instance.
module tb_mem_data_arb;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_data_arb_if #(.NCHAN(4), .AW(6), .NBDATA(16)) b0 ();
    mem_data_arb_if #(.NCHAN(2), .AW(6), .NBDATA(16)) b1 ();

    mem_data_arb #(.NADDRE(64), .NBDATA(16), .NCHAN(4), .FWD(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    mem_data_arb #(.NADDRE(48), .NBDATA(16), .NCHAN(2), .FWD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    int n_chk  = 0;
    int n_pass = 0;
    logic [15:0] exp_d [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b0.core_wr = 0; b0.core_addr_w = '0; b0.core_din = '0;
        b0.core_rd = 0; b0.core_addr_r = '0;
        b0.ext_req = '0; b0.ext_we = '0; b0.ext_addr = '0; b0.ext_wdata = '0;
        b1.core_wr = 0; b1.core_addr_w = '0; b1.core_din = '0;
        b1.core_rd = 0; b1.core_addr_r = '0;
        b1.ext_req = '0; b1.ext_we = '0; b1.ext_addr = '0; b1.ext_wdata = '0;
    endtask

    initial begin
        idle();
        b0.ext_req = 4'hF;
        repeat (2) tick();
        chk("rst_core_dout", b0.core_dout, 0);
        chk("rst_rvalid", b0.ext_rvalid, 0);
        chk("rst_rdata", b0.ext_rdata, 0);
        chk("rst_gnt", b0.ext_gnt, 0);
        b0.ext_req = '0;
        rst_n = 1'b1;
        tick();

        // core write then read
        b0.core_wr = 1; b0.core_addr_w = 6'd5; b0.core_din = 16'h1234;
        tick();
        b0.core_wr = 0; b0.core_rd = 1; b0.core_addr_r = 6'd5;
        tick();
        b0.core_rd = 0; b0.core_addr_r = 6'd6;
        chk("core_rd", b0.core_dout, 16'h1234);
        tick();
        chk("core_hold", b0.core_dout, 16'h1234);

        // forwarding, FWD=1
        b0.core_wr = 1; b0.core_addr_w = 6'd7; b0.core_din = 16'h1111;
        tick();
        b0.core_din = 16'hBEEF;
        b0.ext_req = 4'b0001; b0.ext_we = 4'b0000; b0.ext_addr[0] = 6'd7;
        #1 chk("fwd1_gnt", b0.ext_gnt, 4'b0001);
        tick();
        b0.core_wr = 0; b0.ext_req = '0;
        chk("fwd1_rvalid", b0.ext_rvalid, 4'b0001);
        chk("fwd1_rdata", b0.ext_rdata, 16'hBEEF);
        tick();
        chk("rvalid_pulse", b0.ext_rvalid, 0);
        chk("rdata_hold", b0.ext_rdata, 16'hBEEF);

        // forwarding off, FWD=0
        b1.core_wr = 1; b1.core_addr_w = 6'd7; b1.core_din = 16'h1111;
        tick();
        b1.core_din = 16'hBEEF;
        b1.ext_req = 2'b01; b1.ext_we = 2'b00; b1.ext_addr[0] = 6'd7;
        #1 chk("fwd0_gnt", b1.ext_gnt, 2'b01);
        tick();
        b1.core_wr = 0; b1.ext_req = '0;
        chk("fwd0_rdata", b1.ext_rdata, 16'h1111);
        chk("fwd0_rvalid", b1.ext_rvalid, 2'b01);
        b1.core_rd = 1; b1.core_addr_r = 6'd7;
        tick();
        b1.core_rd = 0;
        chk("fwd0_written", b1.core_dout, 16'hBEEF);

        // out-of-range on 48-word instance (pointer now 1)
        b1.ext_req = 2'b10; b1.ext_we = 2'b10; b1.ext_addr[1] = 6'd50; b1.ext_wdata[1] = 16'h7777;
        #1 chk("oor_wr_gnt", b1.ext_gnt, 2'b10);
        tick();
        b1.ext_req = 2'b01; b1.ext_we = 2'b00; b1.ext_addr[0] = 6'd50;
        #1 chk("oor_rd_gnt", b1.ext_gnt, 2'b01);
        tick();
        b1.ext_req = '0;
        chk("oor_rvalid", b1.ext_rvalid, 2'b01);
        chk("oor_rdata", b1.ext_rdata, 0);

        // contention: ext write blocked while core writes (u0 pointer = 1)
        b0.core_wr = 1; b0.core_addr_w = 6'd20; b0.core_din = 16'h0020;
        b0.ext_req = 4'b0001; b0.ext_we = 4'b0001; b0.ext_addr[0] = 6'd9; b0.ext_wdata[0] = 16'hABCD;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("wr_block%0d", i), b0.ext_gnt, 0);
            tick();
        end
        b0.core_wr = 0;
        #1 chk("wr_unblock", b0.ext_gnt, 4'b0001);
        tick();
        b0.ext_we = 4'b0000; b0.core_rd = 1; b0.core_addr_r = 6'd9;
        #1 chk("rd_block0", b0.ext_gnt, 0);
        tick();
        chk("ext_wr_data", b0.core_dout, 16'hABCD);
        b0.core_addr_r = 6'd5;
        #1 chk("rd_block1", b0.ext_gnt, 0);
        tick();
        chk("core_rd2", b0.core_dout, 16'h1234);
        b0.core_rd = 0;
        #1 chk("rd_unblock", b0.ext_gnt, 4'b0001);
        tick();
        b0.ext_req = '0;
        chk("rd_unblock_rvalid", b0.ext_rvalid, 4'b0001);
        chk("rd_unblock_rdata", b0.ext_rdata, 16'hABCD);

        // core read and ext write share a cycle
        b0.core_rd = 1; b0.core_addr_r = 6'd7;
        b0.ext_req = 4'b0001; b0.ext_we = 4'b0001; b0.ext_addr[0] = 6'd10; b0.ext_wdata[0] = 16'h5555;
        #1 chk("both_gnt", b0.ext_gnt, 4'b0001);
        tick();
        b0.ext_req = '0; b0.ext_we = '0;
        chk("both_core", b0.core_dout, 16'hBEEF);
        b0.core_addr_r = 6'd10;
        tick();
        b0.core_rd = 0;
        chk("both_ext_wr", b0.core_dout, 16'h5555);

        // skip blocked ch1 write, grant ch2 read (pointer = 1)
        b0.core_wr = 1; b0.core_addr_w = 6'd30; b0.core_din = 16'h0000;
        b0.ext_req = 4'b0110; b0.ext_we = 4'b0010;
        b0.ext_addr[1] = 6'd11; b0.ext_wdata[1] = 16'hDEAD; b0.ext_addr[2] = 6'd9;
        #1 chk("skip_gnt", b0.ext_gnt, 4'b0100);
        tick();
        b0.core_wr = 0; b0.ext_req = '0; b0.ext_we = '0;
        chk("skip_rvalid", b0.ext_rvalid, 4'b0100);
        chk("skip_rdata", b0.ext_rdata, 16'hABCD);

        // fairness: all read continuously, pointer starts at 3
        b0.ext_addr[0] = 6'd5;  exp_d[0] = 16'h1234;
        b0.ext_addr[1] = 6'd7;  exp_d[1] = 16'hBEEF;
        b0.ext_addr[2] = 6'd9;  exp_d[2] = 16'hABCD;
        b0.ext_addr[3] = 6'd10; exp_d[3] = 16'h5555;
        b0.ext_req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            int c;
            c = (3 + n) % 4;
            #1 chk($sformatf("rr_gnt%0d", n), b0.ext_gnt, 32'(4'b0001 << c));
            tick();
            chk($sformatf("rr_rvalid%0d", n), b0.ext_rvalid, 32'(4'b0001 << c));
            chk($sformatf("rr_rdata%0d", n), b0.ext_rdata, exp_d[c]);
        end

        // reset while a read is outstanding (ch3 granted, pointer back to 3)
        #1 chk("pre_rst_gnt", b0.ext_gnt, 4'b1000);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", b0.ext_rvalid, 0);
        chk("mid_rst_gnt", b0.ext_gnt, 0);
        chk("mid_rst_core_dout", b0.core_dout, 0);
        chk("mid_rst_rdata", b0.ext_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ptr", b0.ext_gnt, 4'b0001);
        tick();
        b0.ext_req = '0;
        chk("post_rst_rvalid", b0.ext_rvalid, 4'b0001);
        chk("post_rst_rdata", b0.ext_rdata, 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
